// File: rtl/seven_segment_display_ctrl.sv
// Multi-digit seven-segment display controller: captures a binary value on load
// and renders it in hex, or in decimal through a sequential double-dabble converter.
module seven_segment_display_ctrl #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int EXT_W = (BCD_W > DATA_W) ? BCD_W : DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {IDLE, SHIFT, RENDER} state_t;

  state_t             state;
  state_t             next_state;
  logic [DATA_W-1:0]  value_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_corr;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_flag;
  logic               hex_mode_reg;
  logic               blank_lz_reg;
  logic [EXT_W-1:0]   value_ext;
  logic [3:0]         nib [DIGITS];
  logic               seen_nonzero;
  logic               render_ovf;
  logic [7*DIGITS-1:0] render_hex;
  logic [6:0]         seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = hex_mode ? RENDER : SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(DATA_W - 1)) next_state = RENDER;
      RENDER:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Double-dabble correction step: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_corr = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_corr[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    value_ext    = EXT_W'(value_reg);
    render_ovf   = 1'b0;
    seen_nonzero = 1'b0;
    render_hex   = '0;
    seg          = SEG_BLANK;
    nib          = '{default: '0};
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = hex_mode_reg ? value_ext[4*i +: 4] : bcd[4*i +: 4];
    end
    if (hex_mode_reg) begin
      for (int b = 0; b < EXT_W; b++) begin
        if (b >= BCD_W) render_ovf = render_ovf | value_ext[b];
      end
    end else begin
      render_ovf = ovf_flag;
    end
    // Walk from the top digit down so blanking stops at the first nonzero nibble.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (nib[i] != 4'd0) seen_nonzero = 1'b1;
      if (render_ovf)                              seg = SEG_DASH;
      else if (blank_lz_reg && !seen_nonzero && i != 0) seg = SEG_BLANK;
      else                                         seg = seg_decode(nib[i]);
      render_hex[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value_reg    <= '0;
      shift_reg    <= '0;
      bcd          <= '0;
      bit_cnt      <= '0;
      ovf_flag     <= 1'b0;
      hex_mode_reg <= 1'b0;
      blank_lz_reg <= 1'b0;
      hex_out      <= '0;
      ovf          <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            value_reg    <= value;
            shift_reg    <= value;
            hex_mode_reg <= hex_mode;
            blank_lz_reg <= blank_lz;
            bcd          <= '0;
            bit_cnt      <= '0;
            ovf_flag     <= 1'b0;
          end
        end
        SHIFT: begin
          bcd       <= {bcd_corr[BCD_W-2:0], shift_reg[DATA_W-1]};
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          ovf_flag  <= ovf_flag | bcd_corr[BCD_W-1];
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end
        RENDER: begin
          hex_out <= render_hex;
          ovf     <= render_ovf;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_display_ctrl.sv
// Directed self-checking bench for seven_segment_display_ctrl (DATA_W=32, DIGITS=6)
// using hand-computed segment patterns and edge-counted latencies.
module tb_seven_segment_display_ctrl;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S9 = 7'b1111011, SB = 7'b0011111, SE = 7'b1001111,
                         SF = 7'b1000111, BL = 7'b0000000, DS = 7'b0000001;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [41:0] hex_out;

  int checks = 0;
  int errors = 0;

  seven_segment_display_ctrl #(.DATA_W(32), .DIGITS(6)) dut (
    .clock(clock), .resetn(resetn), .value(value), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy), .done(done),
    .ovf(ovf), .hex_out(hex_out)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Waits (bounded) for done; edges counted with the load edge as edge 1.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] v, input logic hm,
                                input logic blz, input int exp_lat,
                                input logic [41:0] exp_hex, input logic exp_ovf);
    int edges;
    value = v; hex_mode = hm; blank_lz = blz; load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    load = 1'b0;
    check_output({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(edges);
    check_output({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check_output({tag, "_hex"}, 64'(hex_out), 64'(exp_hex));
    check_output({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    check_output({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clock);
    check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int edges;
    int saw_done;
    repeat (2) @(negedge clock);
    check_output("reset_hex", 64'(hex_out), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_ovf", 64'(ovf), 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    apply_stimulus("dec_12345", 32'd12345, 1'b0, 1'b0, 34, {S0, S1, S2, S3, S4, S5}, 1'b0);
    apply_stimulus("hex_beef", 32'h0000BEEF, 1'b1, 1'b1, 2, {BL, BL, SB, SE, SE, SF}, 1'b0);
    apply_stimulus("dec_1e6", 32'd1000000, 1'b0, 1'b0, 34, {6{DS}}, 1'b1);
    apply_stimulus("dec_999999", 32'd999999, 1'b0, 1'b0, 34, {6{S9}}, 1'b0);
    apply_stimulus("hex_ovf", 32'h01000000, 1'b1, 1'b0, 2, {6{DS}}, 1'b1);
    apply_stimulus("dec_zero_lz", 32'd0, 1'b0, 1'b1, 34, {BL, BL, BL, BL, BL, S0}, 1'b0);

    // Handshake: load during busy is ignored, load in the done cycle is accepted
    value = 32'd12; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    value = 32'd77;
    repeat (3) @(negedge clock);
    load = 1'b0;
    edges = 1;
    while (!done && edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check_output("hs_first_done", 64'(done), 64'd1);
    check_output("hs_first_hex", 64'(hex_out), 64'({S0, S0, S0, S0, S1, S2}));
    value = 32'd5; blank_lz = 1'b1; load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    load = 1'b0;
    check_output("hs_second_busy", 64'(busy), 64'd1);
    wait_done(edges);
    check_output("hs_second_latency", 64'(edges), 64'd34);
    check_output("hs_second_hex", 64'(hex_out), 64'({BL, BL, BL, BL, BL, S5}));
    @(negedge clock);

    // Reset in the middle of a decimal conversion aborts it
    value = 32'd4321; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    load = 1'b0;
    repeat (10) @(negedge clock);
    load = 1'b1;
    check_output("mid_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check_output("mid_reset_hex", 64'(hex_out), 64'd0);
    check_output("mid_reset_busy", 64'(busy), 64'd0);
    @(negedge clock);
    load = 1'b0;
    resetn = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    check_output("mid_no_done", 64'(saw_done), 64'd0);
    check_output("mid_hex_blank", 64'(hex_out), 64'd0);
    check_output("mid_ovf", 64'(ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
